picorv32_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single PicoRV32 native memory port (valid/ready, addr, wdata, wstrb, rdata) between the CPU core (requester 0) and a program-loader/debug master (requester 1). It sits between the masters and the RAM/UART-TX address space. It registers one transaction at a time onto the shared slave port and returns the response to the granted master. Round-robin fairness prevents the loader from starving the core, and the core from starving the loader.

---
 rtl/picorv32_bus_pkg.sv | 33 +++
 rtl/picorv32_rr_pick.sv | 20 ++
 rtl/picorv32_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_bus_pkg.sv
// Shared definitions for the PicoRV32 native-bus arbiter: state encoding,
// well-known addresses/data words and the request payload record.
package picorv32_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_STRB_W = BUS_DATA_W / 8;

  // Memory-mapped UART transmit register seen through the shared slave port.
  localparam logic [BUS_ADDR_W-1:0] UART_TX_ADDR = 32'h0200_0000;

  // Read data returned to a master whose slave transaction timed out.
  localparam logic [BUS_DATA_W-1:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // One native-interface request as a master presents it.
  typedef struct packed {
    logic                  instr;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_STRB_W-1:0] wstrb;
  } bus_req_t;

  // Requester index to one-hot grant vector.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/picorv32_rr_pick.sv
// Combinational two-way round-robin chooser. A lone requester always wins;
// on a tie the requester that did not win last time is chosen.
module picorv32_rr_pick (
  input  logic [1:0] m_valid,
  input  logic       last_grant,
  output logic [1:0] winner
);

  // One-hot winner from the current requests and the previous owner index.
  always_comb begin
    winner = 2'b00;
    case (m_valid)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_grant ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Two-requester arbiter sharing one PicoRV32 native memory port between the
// CPU core (requester 0) and a loader/debug master (requester 1). One request
// is registered onto the slave port at a time; the response is steered back
// to the owner. Optional slave-response timeout: define MEM_ARB_TIMEOUT_EN.
module picorv32_mem_arbiter
  import picorv32_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            m_valid,
  input  logic [1:0]            m_instr,
  input  logic [2*ADDR_W-1:0]   m_addr,
  input  logic [2*DATA_W-1:0]   m_wdata,
  input  logic [2*DATA_W/8-1:0] m_wstrb,
  output logic [1:0]            m_ready,
  output logic [DATA_W-1:0]     m_rdata,
  output logic                  s_valid,
  output logic                  s_instr,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_ready,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            grant,
  output logic                  err
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              s_valid_q, s_valid_d;
  logic              s_instr_q, s_instr_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic [STRB_W-1:0] s_wstrb_q, s_wstrb_d;

  logic [1:0]        winner;
  logic              win_idx;
  logic              timeout_hit;
  logic              done;

  picorv32_rr_pick u_rr_pick (
    .m_valid    (m_valid),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  assign win_idx = winner[1];

  // A BUSY cycle ends the transaction on slave completion or on timeout.
  assign done = (state_q == BUSY) && (s_ready || timeout_hit);

  // Completion strobe only for the owner, only in the finishing BUSY cycle;
  // s_ready seen in IDLE never reaches a master.
  assign m_ready = done ? grant_q : 2'b00;

  // Next-state and next slave-request computation for the two-state FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_valid_d    = s_valid_q;
    s_instr_d    = s_instr_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_wstrb_d    = s_wstrb_q;

    case (state_q)
      IDLE: begin
        if (winner != 2'b00) begin
          state_d   = BUSY;
          grant_d   = winner;
          s_valid_d = 1'b1;
          s_instr_d = m_instr[win_idx];
          s_addr_d  = win_idx ? m_addr[2*ADDR_W-1:ADDR_W]  : m_addr[ADDR_W-1:0];
          s_wdata_d = win_idx ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
          s_wstrb_d = win_idx ? m_wstrb[2*STRB_W-1:STRB_W] : m_wstrb[STRB_W-1:0];
        end
      end
      BUSY: begin
        // Payload is held; a master dropping m_valid here does not abort.
        if (done) begin
          state_d      = IDLE;
          grant_d      = 2'b00;
          s_valid_d    = 1'b0;
          last_grant_d = grant_q[1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered slave-port / grant outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      s_valid_q    <= 1'b0;
      s_instr_q    <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_wstrb_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      s_valid_q    <= s_valid_d;
      s_instr_q    <= s_instr_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      s_wstrb_q    <= s_wstrb_d;
    end
  end

  assign s_valid = s_valid_q;
  assign s_instr = s_instr_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_wstrb = s_wstrb_q;
  assign grant   = grant_q;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // The counter sits at zero in IDLE, so it is already clear on BUSY entry;
  // the first BUSY cycle sees 0 and the TIMEOUT-th sees TIMEOUT-1.
  assign timeout_hit = (state_q == BUSY) && !s_ready
                       && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Stall counter and sticky error flag.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q != BUSY) begin
      cnt_d = '0;
    end else if (!s_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  // Timeout counter and error registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err     = err_q;
  // A real completion in the same cycle wins, since timeout_hit needs !s_ready.
  assign m_rdata = timeout_hit ? DATA_W'(BUS_ERR_DATA) : s_rdata;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
  assign m_rdata     = s_rdata;
`endif

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Self-checking bench for picorv32_mem_arbiter. Stimulus pushes expected
// requests into per-master queues; a negedge monitor pops and compares them
// against the slave port and the master responses, predicting ownership from
// the round-robin rule and read data from a sparse memory model.
`timescale 1ns/1ps
module tb_picorv32_mem_arbiter;
  import picorv32_bus_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [1:0]      m_valid;
  logic [1:0]      m_instr;
  logic [2*AW-1:0] m_addr;
  logic [2*DW-1:0] m_wdata;
  logic [2*SW-1:0] m_wstrb;
  logic [1:0]      m_ready;
  logic [DW-1:0]   m_rdata;
  logic            s_valid, s_instr;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_ready = 1'b0;
  logic [DW-1:0]   s_rdata = '0;
  logic [1:0]      grant;
  logic            err;

  // Master-side drive state, written only by the main stimulus process.
  logic [1:0]    mv = 2'b00;
  logic [1:0]    act = 2'b00;
  logic          instr_r [2] = '{1'b0, 1'b0};
  logic [AW-1:0] addr_r  [2] = '{'0, '0};
  logic [DW-1:0] wdata_r [2] = '{'0, '0};
  logic [SW-1:0] wstrb_r [2] = '{'0, '0};

  assign m_valid = mv;
  assign m_instr = {instr_r[1], instr_r[0]};
  assign m_addr  = {addr_r[1],  addr_r[0]};
  assign m_wdata = {wdata_r[1], wdata_r[0]};
  assign m_wstrb = {wstrb_r[1], wstrb_r[0]};

  always #5 clk = ~clk;

  picorv32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .err(err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bus_req_t    exp_q [2][$];
  logic [31:0] mem [logic [31:0]];
  logic [1:0]  grant_log [$];
  int          last_w  = 1;
  logic        exp_err = 1'b0;
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit          auto_en [2] = '{1'b0, 1'b0};
  int          auto_pct = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [1:0] oh(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h0F1E_2D3C;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    logic [31:0] w;
    w = mem_rd(a);
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
    mem[a] = w;
  endtask

  function automatic bus_req_t mk_req(input logic instr, input logic [31:0] a,
                                      input logic [31:0] d, input logic [3:0] strb);
    bus_req_t r;
    r.instr = instr; r.addr = a; r.wdata = d; r.wstrb = strb;
    return r;
  endfunction

  function automatic bus_req_t rand_req();
    logic [3:0] strb;
    strb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
    return mk_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom, strb);
  endfunction

  task automatic issue(input int i, input bus_req_t r);
    exp_q[i].push_back(r);
    act[i] = 1'b1; mv[i] = 1'b1;
    instr_r[i] = r.instr; addr_r[i] = r.addr; wdata_r[i] = r.wdata; wstrb_r[i] = r.wstrb;
  endtask

  // One clock: retire masters that saw m_ready, optionally reissue, drive slave.
  task automatic step();
    logic [1:0] rdy;
    @(negedge clk);
    rdy = m_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (rdy[i]) begin act[i] = 1'b0; mv[i] = 1'b0; end
    for (int i = 0; i < 2; i++)
      if (!act[i] && auto_en[i] && $urandom_range(0, 99) < auto_pct) issue(i, rand_req());
    case (ready_mode)
      0:       s_ready = 1'b1;
      1:       s_ready = ($urandom_range(0, 3) != 0);
      default: s_ready = 1'b0;
    endcase
    s_rdata = mem_rd(s_addr);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((act != 2'b00 || s_valid) && k < budget) begin step(); k++; end
    if (act != 2'b00 || s_valid) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, act=%b", budget, act);
    end
  endtask

  // Scoreboard monitor: predicts owner, checks slave request and responses.
  initial begin : monitor
    logic       prev_sv;
    logic [1:0] prev_mv;
    int         owner, busy;
    bus_req_t   e;
    logic       to;
    prev_sv = 1'b0; prev_mv = 2'b00; owner = 0; busy = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_sv = 1'b0; prev_mv = 2'b00; busy = 0; last_w = 1; exp_err = 1'b0;
      end else begin
        check("err_flag", err, exp_err);
        if (s_valid && !prev_sv) begin
          if (prev_mv == 2'b00) check("grant_without_request", s_valid, 1'b0);
          else begin
            owner = (prev_mv == 2'b01) ? 0 : (prev_mv == 2'b10) ? 1 : ((last_w == 0) ? 1 : 0);
            check("grant_pick", grant, oh(owner));
            grant_log.push_back(grant);
          end
          busy = 0;
        end
        if (s_valid) begin
          busy++;
          if (exp_q[owner].size() == 0) check("slave_req_unexpected", s_valid, 1'b0);
          else begin
            e = exp_q[owner][0];
            check("slave_req", {s_instr, s_addr, s_wdata, s_wstrb}, e);
            check("grant_hold", grant, oh(owner));
            to = TO_EN && !s_ready && (busy == TO);
            if (s_ready || to) begin
              check("m_ready_done", m_ready, oh(owner));
              if (to) begin
                check("m_rdata_timeout", m_rdata, BUS_ERR_DATA);
                exp_err = 1'b1;
              end else if (e.wstrb == 4'b0000) begin
                check("m_rdata", m_rdata, mem_rd(e.addr));
              end else begin
                mem_wr(e.addr, e.wdata, e.wstrb);
              end
              void'(exp_q[owner].pop_front());
              last_w = owner;
            end else begin
              check("m_ready_stall", m_ready, 2'b00);
            end
          end
        end else begin
          check("idle_m_ready", m_ready, 2'b00);
          check("idle_grant", grant, 2'b00);
        end
        prev_sv = s_valid; prev_mv = m_valid;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0] exp_seq [4];
    int k;
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {s_valid, s_instr, s_addr, s_wdata, s_wstrb, grant, err}, '0);
    resetn = 1'b1;

    // Tie right after reset: continuous demand must alternate 0,1,0,1.
    ready_mode = 0; auto_pct = 100; auto_en = '{1'b1, 1'b1};
    grant_log.delete();
    issue(0, rand_req()); issue(1, rand_req());
    k = 0;
    while (grant_log.size() < 4 && k < 40) begin step(); k++; end
    auto_en = '{1'b0, 1'b0};
    wait_idle(40);
    for (int i = 0; i < 4; i++)
      check($sformatf("tie_seq_%0d", i), (grant_log.size() > i) ? grant_log[i] : 2'b00, exp_seq[i]);

    // CPU-only read of a known word.
    mem[32'h100] = 32'h1234_5678;
    issue(0, mk_req(1'b0, 32'h100, 32'h0, 4'b0000));
    wait_idle(20);

    // Loader byte write to the UART transmit register, then read it back.
    issue(1, mk_req(1'b0, UART_TX_ADDR, 32'h0000_00A5, 4'b0001));
    wait_idle(20);
    issue(1, mk_req(1'b0, UART_TX_ADDR, 32'h0, 4'b0000));
    wait_idle(20);

    // Slave stalls five BUSY cycles, completes on the sixth.
    ready_mode = 2;
    issue(0, mk_req(1'b0, 32'h40, 32'hCAFE_F00D, 4'b1010));
    k = 0;
    while (!s_valid && k < 10) begin step(); k++; end
    repeat (4) step();
    ready_mode = 0;
    wait_idle(20);
    issue(0, mk_req(1'b1, 32'h40, 32'h0, 4'b0000));
    wait_idle(20);

    // Randomised traffic with random slave back-pressure.
    ready_mode = 1; auto_pct = 40; auto_en = '{1'b1, 1'b1};
    repeat (500) step();
    auto_en = '{1'b0, 1'b0};
    wait_idle(200);

    // Asynchronous reset in the middle of a stalled transaction.
    ready_mode = 2;
    issue(1, rand_req());
    k = 0;
    while (!s_valid && k < 10) begin step(); k++; end
    step();
    #3;
    resetn = 1'b0;
    #1;
    check("reset_mid_busy", {s_valid, grant, m_ready}, 5'b0);
    exp_q[0].delete(); exp_q[1].delete();
    act = 2'b00; mv = 2'b00;
    ready_mode = 0; s_ready = 1'b1;
    @(posedge clk); #1;
    issue(0, rand_req()); issue(1, rand_req());
    @(posedge clk); #1;
    resetn = 1'b1;
    step();
    check("tie_after_reset", grant, 2'b01);
    wait_idle(20);

`ifdef MEM_ARB_TIMEOUT_EN
    // Unresponsive slave: timeout completion, then a good transaction.
    ready_mode = 2;
    issue(0, mk_req(1'b0, 32'h80, 32'h0, 4'b0000));
    wait_idle(4 * TO);
    ready_mode = 0;
    issue(1, mk_req(1'b0, 32'h80, 32'h0, 4'b0000));
    wait_idle(20);
    step();
    check("err_sticky", err, 1'b1);
`endif

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
